data_memory_axil: RTL and testbench
===================================

DATA_MEMORY_AXIL -- requirements
Module: data_memory_axil

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, memory size in XLEN-bit words, power of two.
REQ-003 SHALL have ports, one per line:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- i_dm_awvalid  input  1  write address valid.
- o_dm_awready  output  1  write address ready.
- i_dm_awaddr  input  XLEN  write byte address.
- i_dm_wvalid  input  1  write data valid.
- o_dm_wready  output  1  write data ready.
- i_dm_wdata  input  XLEN  write data.
- i_dm_wstrb  input  XLEN/8  byte write enables.
- o_dm_bvalid  output  1  write response valid.
- i_dm_bready  input  1  write response ready.
- o_dm_bresp  output  2  write response: 00 OKAY, 10 SLVERR.
- i_dm_arvalid  input  1  read address valid.
- o_dm_arready  output  1  read address ready.
- i_dm_araddr  input  XLEN  read byte address.
- o_dm_rvalid  output  1  read data valid.
- i_dm_rready  input  1  read data ready.
- o_dm_rdata  output  XLEN  read data.
- o_dm_rresp  output  2  read response: 00 OKAY, 10 SLVERR.

Function
REQ-004 SHALL hold DEPTH words; word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
REQ-005 SHALL treat an address as out of range when any bit above log2(DEPTH)+1 is set.
REQ-006 SHALL accept AW and W independently, each into a one-entry holding register with a full flag (aw_full, w_full).
REQ-007 SHALL drive o_dm_awready = rstn & !aw_full & !o_dm_bvalid, and o_dm_wready = rstn & !w_full & !o_dm_bvalid.
REQ-008 SHALL set aw_full/w_full on the edge where the respective valid and ready are both high.
REQ-009 SHALL commit on any edge where aw_full & w_full & !o_dm_bvalid: write byte lanes with wstrb[i]=1, clear both full flags, set o_dm_bvalid.
REQ-010 SHALL skip the memory write on commit if the address is out of range, responding SLVERR; otherwise OKAY.
REQ-011 SHALL treat wstrb = 0 as a no-op write with OKAY response.
REQ-012 SHALL give a write latency of AW-and-W-both-accepted edge N -> commit at edge N+1 -> o_dm_bvalid high in the cycle after N+1.
REQ-013 SHALL hold o_dm_bvalid and o_dm_bresp stable until i_dm_bready, and clear o_dm_bvalid on the edge where bvalid & bready.
REQ-014 SHALL accept no new AW/W while o_dm_bvalid is high (at most one write in flight).
REQ-015 SHALL drive o_dm_arready = rstn & (!o_dm_rvalid | i_dm_rready).
REQ-016 SHALL, on an AR handshake at edge N, register o_dm_rdata and o_dm_rresp and assert o_dm_rvalid after edge N (1-cycle latency).
REQ-017 SHALL support back-to-back reads: AR accepted in the same cycle an R handshake completes, with rvalid staying high.
REQ-018 SHALL return rdata = 0 and SLVERR for an out-of-range read.
REQ-019 SHALL hold o_dm_rdata and o_dm_rresp stable while o_dm_rvalid & !i_dm_rready.
REQ-020 SHALL give read-before-write: a read and a commit to the same word on the same edge return the pre-write data.

Reset
REQ-021 SHALL, on an edge with rstn=0, clear aw_full, w_full, o_dm_bvalid and o_dm_rvalid, and zero o_dm_bresp, o_dm_rresp and o_dm_rdata.
REQ-022 SHALL hold all ready outputs at 0 while rstn=0, and drive them to 1 in the first cycle after reset release.
REQ-023 SHALL abandon any partially accepted AW/W or pending response on reset mid-operation, with no memory write; memory contents are not reset.

Verification
REQ-024 SHALL cover a simultaneous AW 0x10 / W 0xDEADBEEF, strb 0xF: bvalid OKAY two cycles later; then a read of 0x10 returns 0xDEADBEEF OKAY, rvalid one cycle after AR.
REQ-025 SHALL cover W 0x000000AA, strb 0x1 before AW 0x10 (3 cycles later) over 0xDEADBEEF: wready low after W accepted; a read returns 0xDEADBEAA.
REQ-026 SHALL cover a write to 0x1000 with DEPTH=1024: bresp SLVERR, no memory change; a read of 0x1000 gives rdata 0, SLVERR.
REQ-027 SHALL cover bready held low 5 cycles: bvalid and bresp stable, awready/wready low, with a second AW presented not accepted until after the B handshake.
REQ-028 SHALL cover reads of 0x0, 0x4, 0x8 back-to-back with rready=1: one result per cycle, in order; with rready=0 the first result is held and arready is low.
REQ-029 SHALL cover rstn low for 1 cycle after AW accepted but W not: no write occurs and all valids are 0; a subsequent full write works normally.

Source files
------------

// File: rtl/data_memory_axil.sv
// AXI4-Lite word-addressed data memory: independent AW/W holding registers, single write in flight.
// Write: commit one edge after AW and W are both held, B one cycle later; read data registered with 1-cycle latency.
module data_memory_axil #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_dm_awvalid,
    output logic              o_dm_awready,
    input  logic [XLEN-1:0]   i_dm_awaddr,
    input  logic              i_dm_wvalid,
    output logic              o_dm_wready,
    input  logic [XLEN-1:0]   i_dm_wdata,
    input  logic [XLEN/8-1:0] i_dm_wstrb,
    output logic              o_dm_bvalid,
    input  logic              i_dm_bready,
    output logic [1:0]        o_dm_bresp,
    input  logic              i_dm_arvalid,
    output logic              o_dm_arready,
    input  logic [XLEN-1:0]   i_dm_araddr,
    output logic              o_dm_rvalid,
    input  logic              i_dm_rready,
    output logic [XLEN-1:0]   o_dm_rdata,
    output logic [1:0]        o_dm_rresp
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = XLEN / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [XLEN-1:0] mem_q [DEPTH];

    logic            aw_full_q, w_full_q;
    logic [AW-1:0]   aw_idx_q;
    logic            aw_oor_q;
    logic [XLEN-1:0] w_data_q;
    logic [NB-1:0]   w_strb_q;
    logic            bvalid_q, rvalid_q;
    logic [1:0]      bresp_q, rresp_q;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [1:0]      rresp_d;

    logic          aw_oor, ar_oor, commit;
    logic [AW-1:0] ar_idx;
    logic          unused_addr_bits;

    assign aw_oor = |i_dm_awaddr[XLEN-1:AW+2];
    assign ar_oor = |i_dm_araddr[XLEN-1:AW+2];
    assign ar_idx = i_dm_araddr[AW+1:2];
    assign unused_addr_bits = ^{i_dm_awaddr[1:0], i_dm_araddr[1:0]};

    assign commit       = aw_full_q & w_full_q & ~bvalid_q;
    assign o_dm_awready = rstn & ~aw_full_q & ~bvalid_q;
    assign o_dm_wready  = rstn & ~w_full_q & ~bvalid_q;
    assign o_dm_arready = rstn & (~rvalid_q | i_dm_rready);

    assign o_dm_bvalid = bvalid_q;
    assign o_dm_bresp  = bresp_q;
    assign o_dm_rvalid = rvalid_q;
    assign o_dm_rdata  = rdata_q;
    assign o_dm_rresp  = rresp_q;

    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
        if (!ar_oor) begin
            rdata_d = mem_q[ar_idx];
            rresp_d = RESP_OKAY;
        end
    end

    // Control state; payload registers below carry no reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            if (i_dm_awvalid && o_dm_awready)
                aw_full_q <= 1'b1;
            else if (commit)
                aw_full_q <= 1'b0;

            if (i_dm_wvalid && o_dm_wready)
                w_full_q <= 1'b1;
            else if (commit)
                w_full_q <= 1'b0;

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_oor_q ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && i_dm_bready) begin
                bvalid_q <= 1'b0;
            end

            if (i_dm_arvalid && o_dm_arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (i_dm_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_dm_awvalid && o_dm_awready) begin
            aw_idx_q <= i_dm_awaddr[AW+1:2];
            aw_oor_q <= aw_oor;
        end
        if (i_dm_wvalid && o_dm_wready) begin
            w_data_q <= i_dm_wdata;
            w_strb_q <= i_dm_wstrb;
        end
    end

    // Same-edge read sees the old word since both sides use non-blocking updates.
    always_ff @(posedge clk) begin
        if (rstn && commit && !aw_oor_q) begin
            for (int i = 0; i < NB; i++) begin
                if (w_strb_q[i])
                    mem_q[aw_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory_axil.sv
// Directed bench for data_memory_axil with hand-computed expectations.
module tb_data_memory_axil;
    logic        clk = 1'b0;
    logic        rstn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_memory_axil #(.XLEN(32), .DEPTH(1024)) dut (
        .clk(clk), .rstn(rstn),
        .i_dm_awvalid(awvalid), .o_dm_awready(awready), .i_dm_awaddr(awaddr),
        .i_dm_wvalid(wvalid), .o_dm_wready(wready), .i_dm_wdata(wdata), .i_dm_wstrb(wstrb),
        .o_dm_bvalid(bvalid), .i_dm_bready(bready), .o_dm_bresp(bresp),
        .i_dm_arvalid(arvalid), .o_dm_arready(arready), .i_dm_araddr(araddr),
        .o_dm_rvalid(rvalid), .i_dm_rready(rready), .o_dm_rdata(rdata), .o_dm_rresp(rresp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] r);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        #1;
        check({tag, "/awready"}, 32'(awready), 32'd1);
        check({tag, "/wready"}, 32'(wready), 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check({tag, "/bvalid_early"}, 32'(bvalid), 32'd0);
        step();
        check({tag, "/bvalid"}, 32'(bvalid), 32'd1);
        check({tag, "/bresp"}, 32'(bresp), 32'(r));
        bready = 1'b1;
        step();
        bready = 1'b0;
        #1;
        check({tag, "/bvalid_clr"}, 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] r);
        arvalid = 1'b1; araddr = a; rready = 1'b0;
        #1;
        check({tag, "/arready"}, 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        check({tag, "/rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "/rdata"}, rdata, d);
        check({tag, "/rresp"}, 32'(rresp), 32'(r));
        rready = 1'b1;
        step();
        rready = 1'b0;
        #1;
        check({tag, "/rvalid_clr"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;

        // Reset state
        step();
        check("rst/awready", 32'(awready), 32'd0);
        check("rst/wready", 32'(wready), 32'd0);
        check("rst/arready", 32'(arready), 32'd0);
        check("rst/bvalid", 32'(bvalid), 32'd0);
        check("rst/rvalid", 32'(rvalid), 32'd0);
        check("rst/rdata", rdata, 32'd0);
        check("rst/bresp", 32'(bresp), 32'd0);
        check("rst/rresp", 32'(rresp), 32'd0);
        step();
        rstn = 1'b1;
        #1;
        check("rel/awready", 32'(awready), 32'd1);
        check("rel/wready", 32'(wready), 32'd1);
        check("rel/arready", 32'(arready), 32'd1);
        step();

        // Simultaneous AW/W, then read back
        do_write("w10", 32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read("r10", 32'h10, 32'hDEADBEEF, 2'b00);

        // W arrives three cycles ahead of AW, single byte lane
        wvalid = 1'b1; wdata = 32'h000000AA; wstrb = 4'h1;
        step();
        wvalid = 1'b0;
        #1;
        check("wfirst/wready_low", 32'(wready), 32'd0);
        check("wfirst/awready", 32'(awready), 32'd1);
        step();
        step();
        awvalid = 1'b1; awaddr = 32'h10;
        step();
        awvalid = 1'b0;
        #1;
        check("wfirst/bvalid_early", 32'(bvalid), 32'd0);
        step();
        check("wfirst/bvalid", 32'(bvalid), 32'd1);
        check("wfirst/bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        do_read("r10b", 32'h10, 32'hDEADBEAA, 2'b00);

        // Fill words 0..2, then a zero-strobe write must be a no-op
        do_write("w0", 32'h0, 32'h11111111, 4'hF, 2'b00);
        do_write("w4", 32'h4, 32'h22222222, 4'hF, 2'b00);
        do_write("w8", 32'h8, 32'h33333333, 4'hF, 2'b00);
        do_write("wstrb0", 32'h4, 32'hFFFFFFFF, 4'h0, 2'b00);
        do_read("r4", 32'h4, 32'h22222222, 2'b00);

        // Out of range: 0x1000 would alias word 0 if the high bits were dropped
        do_write("woor", 32'h1000, 32'h12345678, 4'hF, 2'b10);
        do_read("roor", 32'h1000, 32'h0, 2'b10);
        do_read("r0", 32'h0, 32'h11111111, 2'b00);

        // B held off for five cycles with a second write waiting
        awvalid = 1'b1; awaddr = 32'h20; wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        awvalid = 1'b1; awaddr = 32'h24; wvalid = 1'b1; wdata = 32'h0BADCAFE;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bhold/bvalid", 32'(bvalid), 32'd1);
            check("bhold/bresp", 32'(bresp), 32'd0);
            check("bhold/awready", 32'(awready), 32'd0);
            check("bhold/wready", 32'(wready), 32'd0);
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        #1;
        check("bhold/bvalid_clr", 32'(bvalid), 32'd0);
        check("bhold/aw2_ready", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        #1;
        check("bhold/b2_early", 32'(bvalid), 32'd0);
        step();
        check("bhold/b2", 32'(bvalid), 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        do_read("r20", 32'h20, 32'hCAFEF00D, 2'b00);
        do_read("r24", 32'h24, 32'h0BADCAFE, 2'b00);

        // Back-to-back reads with rready high
        arvalid = 1'b1; araddr = 32'h0; rready = 1'b1;
        step();
        check("b2b/rv0", 32'(rvalid), 32'd1);
        check("b2b/d0", rdata, 32'h11111111);
        araddr = 32'h4;
        #1;
        check("b2b/arready", 32'(arready), 32'd1);
        step();
        check("b2b/rv1", 32'(rvalid), 32'd1);
        check("b2b/d1", rdata, 32'h22222222);
        araddr = 32'h8;
        step();
        check("b2b/rv2", 32'(rvalid), 32'd1);
        check("b2b/d2", rdata, 32'h33333333);
        arvalid = 1'b0;
        step();
        check("b2b/rv_end", 32'(rvalid), 32'd0);

        // Stalled R: first result held, AR blocked
        arvalid = 1'b1; araddr = 32'h0; rready = 1'b0;
        step();
        araddr = 32'h4;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("stall/rvalid", 32'(rvalid), 32'd1);
            check("stall/rdata", rdata, 32'h11111111);
            check("stall/arready", 32'(arready), 32'd0);
            step();
        end
        rready = 1'b1;
        #1;
        check("stall/arready_rel", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        check("stall/rv_next", 32'(rvalid), 32'd1);
        check("stall/d_next", rdata, 32'h22222222);
        step();
        rready = 1'b0;
        check("stall/rv_end", 32'(rvalid), 32'd0);

        // Reset after AW accepted but before W
        do_write("w30", 32'h30, 32'h55555555, 4'hF, 2'b00);
        awvalid = 1'b1; awaddr = 32'h30;
        step();
        awvalid = 1'b0;
        rstn = 1'b0; wvalid = 1'b1; wdata = 32'h0000DEAD; wstrb = 4'hF;
        #1;
        check("mrst/awready", 32'(awready), 32'd0);
        check("mrst/wready", 32'(wready), 32'd0);
        step();
        rstn = 1'b1; wvalid = 1'b0;
        #1;
        check("mrst/bvalid", 32'(bvalid), 32'd0);
        check("mrst/rvalid", 32'(rvalid), 32'd0);
        check("mrst/awready", 32'(awready), 32'd1);
        check("mrst/wready", 32'(wready), 32'd1);
        step();
        step();
        check("mrst/bvalid_late", 32'(bvalid), 32'd0);
        do_read("r30", 32'h30, 32'h55555555, 2'b00);
        do_write("w30b", 32'h30, 32'h66666666, 4'hF, 2'b00);
        do_read("r30b", 32'h30, 32'h66666666, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
